// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core LSU (port 0, fixed priority) and a DMA
// engine (port 1) share one combinational-read memory. A wait counter plus a
// two-state FSM forces port 1 through after MAX_WAIT refused cycles. Load data
// is registered, and illegal size codes are blocked and reported with an error pulse.
//
// Handshake: reqN is held until granted. gntN is combinational in the same
// cycle. The rising edge where reqN && gntN are both high is the transfer.
// On that edge a store is committed by the memory, and a load is captured into
// rDataN with a one-cycle rvalidN pulse. An illegal size still consumes the
// slot and produces a one-cycle errN pulse instead.
module dmem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              wEn0,
   input  logic              wEn1,
   input  logic [31:0]       addr0,
   input  logic [31:0]       addr1,
   input  logic [31:0]       wData0,
   input  logic [31:0]       wData1,
   input  logic [2:0]        size0,
   input  logic [2:0]        size1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [31:0]       rData0,
   output logic [31:0]       rData1,
   output logic              err0,
   output logic              err1,
   output logic [31:0]       memAddr,
   output logic [31:0]       memWData,
   output logic [2:0]        memSize,
   output logic              memWEn,
   input  logic [31:0]       memRData,
   output logic              dbg_force,
   output logic [WAIT_W-1:0] dbg_wait_cnt
);

   typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              legal0, legal1;
   logic              load_ok0, load_ok1;

   function automatic logic wr_legal(input logic [2:0] sz);
      return (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010);
   endfunction

   function automatic logic rd_legal(input logic [2:0] sz);
      return wr_legal(sz) || (sz == 3'b100) || (sz == 3'b101);
   endfunction

   assign legal0   = wEn0 ? wr_legal(size0) : rd_legal(size0);
   assign legal1   = wEn1 ? wr_legal(size1) : rd_legal(size1);
   assign load_ok0 = gnt0 & ~wEn0 & rd_legal(size0);
   assign load_ok1 = gnt1 & ~wEn1 & rd_legal(size1);

   assign dbg_force    = (state == FORCE);
   assign dbg_wait_cnt = wait_cnt;

   // Grant: forced port 1 first, then port 0, then port 1; nothing during reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if ((state == FORCE) && req1) gnt1 = 1'b1;
         else if (req0)                gnt0 = 1'b1;
         else if (req1)                gnt1 = 1'b1;
      end
   end

   // Memory pin mux: granted port drives the bus; illegal stores never write.
   always_comb begin
      memAddr  = 32'h0;
      memWData = 32'h0;
      memSize  = 3'b010;
      memWEn   = 1'b0;
      if (gnt0) begin
         memAddr  = addr0;
         memWData = wData0;
         memSize  = size0;
         memWEn   = wEn0 & wr_legal(size0);
      end else if (gnt1) begin
         memAddr  = addr1;
         memWData = wData1;
         memSize  = size1;
         memWEn   = wEn1 & wr_legal(size1);
      end
   end

   // Registered load data, valid and error pulses per port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         rData0  <= 32'h0;
         rData1  <= 32'h0;
      end else begin
         rvalid0 <= load_ok0;
         rvalid1 <= load_ok1;
         err0    <= gnt0 & ~legal0;
         err1    <= gnt1 & ~legal1;
         if (load_ok0) rData0 <= memRData;
         if (load_ok1) rData1 <= memRData;
      end
   end

   // Anti-starvation FSM and saturating wait counter for port 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= NORMAL;
         wait_cnt <= '0;
      end else begin
         case (state)
            NORMAL: if (req1 && !gnt1 && (wait_cnt == WAIT_LAST)) state <= FORCE;
            FORCE:  if (gnt1 || !req1) state <= NORMAL;
            default: state <= NORMAL;
         endcase
         if (gnt1 || !req1)            wait_cnt <= '0;
         else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array memory model on the mem pins, and a
// reference model that tracks port-1 refusals as a plain count, plus a shadow
// memory for expected load data. Directed scenarios come first, then random traffic.
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int WAIT_W   = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              req0 = 0, req1 = 0, wEn0 = 0, wEn1 = 0;
   logic [31:0]       addr0 = 0, addr1 = 0, wData0 = 0, wData1 = 0;
   logic [2:0]        size0 = 3'b010, size1 = 3'b010;
   logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, memWEn;
   logic [31:0]       rData0, rData1, memAddr, memWData;
   logic [2:0]        memSize;
   logic [31:0]       mem_rdata;
   logic              dbg_force;
   logic [WAIT_W-1:0] dbg_wait_cnt;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .wEn0(wEn0), .wEn1(wEn1),
      .addr0(addr0), .addr1(addr1), .wData0(wData0), .wData1(wData1),
      .size0(size0), .size1(size1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rData0(rData0), .rData1(rData1), .err0(err0), .err1(err1),
      .memAddr(memAddr), .memWData(memWData), .memSize(memSize), .memWEn(memWEn),
      .memRData(mem_rdata), .dbg_force(dbg_force), .dbg_wait_cnt(dbg_wait_cnt)
   );

   // ---------------- memory model on the DUT pins ----------------
   logic [7:0] mem [0:4095];
   logic [7:0] ref_mem [0:4095];
   int         mem_gen = 0;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 73 + 11) ^ (i >> 3));
   endfunction

   function automatic logic [31:0] ext_load(input logic [7:0] b0, b1, b2, b3,
                                            input logic [2:0] sz);
      case (sz)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b010:  return {b3, b2, b1, b0};
         3'b100:  return {24'h0, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = init_byte(i);
      mem_gen = 1;
      forever begin
         @(posedge clk);
         if (memWEn) begin
            case (memSize)
               3'b000: mem[memAddr[11:0]] <= memWData[7:0];
               3'b001: begin
                  mem[memAddr[11:0]]         <= memWData[7:0];
                  mem[12'(memAddr[11:0] + 1)] <= memWData[15:8];
               end
               3'b010: begin
                  mem[memAddr[11:0]]         <= memWData[7:0];
                  mem[12'(memAddr[11:0] + 1)] <= memWData[15:8];
                  mem[12'(memAddr[11:0] + 2)] <= memWData[23:16];
                  mem[12'(memAddr[11:0] + 3)] <= memWData[31:24];
               end
               default: ;
            endcase
            mem_gen <= mem_gen + 1;
         end
      end
   end

   always @(memAddr or memSize or mem_gen)
      mem_rdata = ext_load(mem[memAddr[11:0]], mem[12'(memAddr[11:0] + 1)],
                           mem[12'(memAddr[11:0] + 2)], mem[12'(memAddr[11:0] + 3)], memSize);

   // ---------------- reference model ----------------
   int          checks = 0, errors = 0;
   int          refused = 0;
   logic        o_g0, o_g1, o_wen, e_g0, e_g1, e_wen;
   logic [31:0] o_addr, o_wdata, e_addr, e_wdata;
   logic [2:0]  o_size, e_size;
   logic [1:0]  o_rv, o_er, e_rv, e_er;
   logic [31:0] o_rd0, o_rd1, e_rd0 = 0, e_rd1 = 0;

   function automatic logic wr_ok(input logic [2:0] sz);
      return sz <= 3'b010;
   endfunction

   function automatic logic rd_ok(input logic [2:0] sz);
      return (sz <= 3'b010) || (sz == 3'b100) || (sz == 3'b101);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] sz);
      logic [11:0] i;
      i = a[11:0];
      return ext_load(ref_mem[i], ref_mem[i + 12'd1], ref_mem[i + 12'd2], ref_mem[i + 12'd3], sz);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      logic [11:0] i;
      int n;
      i = a[11:0];
      n = (sz == 3'b000) ? 1 : (sz == 3'b001) ? 2 : 4;
      for (int k = 0; k < n; k++) ref_mem[i + 12'(k)] = d[8*k +: 8];
   endtask

   task automatic model_reset();
      refused = 0;
      e_rd0   = 32'h0;
      e_rd1   = 32'h0;
   endtask

   // One clock cycle: sample combinational outputs mid-cycle, predict, then
   // sample registered outputs just after the edge.
   task automatic cycle();
      logic        sel1, we, legal, force_m;
      logic [31:0] a, wd;
      logic [2:0]  sz;
      @(negedge clk);
      force_m = (refused >= MAX_WAIT);
      e_g1 = req1 && (force_m || !req0);
      e_g0 = req0 && !e_g1;
      sel1 = e_g1;
      we = sel1 ? wEn1 : wEn0;
      a  = sel1 ? addr1 : addr0;
      wd = sel1 ? wData1 : wData0;
      sz = sel1 ? size1 : size0;
      o_g0 = gnt0; o_g1 = gnt1; o_wen = memWEn;
      o_addr = memAddr; o_wdata = memWData; o_size = memSize;
      e_rv = 2'b00;
      e_er = 2'b00;
      if (e_g0 || e_g1) begin
         legal = we ? wr_ok(sz) : rd_ok(sz);
         e_wen = we && legal; e_addr = a; e_wdata = wd; e_size = sz;
         if (!legal) e_er[sel1] = 1'b1;
         else if (!we) begin
            e_rv[sel1] = 1'b1;
            if (sel1) e_rd1 = ref_read(a, sz); else e_rd0 = ref_read(a, sz);
         end else ref_write(a, wd, sz);
      end else begin
         e_wen = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_size = 3'b010;
      end
      if (req1 && !e_g1) refused = (refused < MAX_WAIT) ? refused + 1 : MAX_WAIT;
      else refused = 0;
      @(posedge clk);
      #1;
      o_rv = {rvalid1, rvalid0};
      o_er = {err1, err0};
      o_rd0 = rData0;
      o_rd1 = rData1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive0(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
      req0 = r; wEn0 = w; addr0 = a; wData0 = d; size0 = s;
   endtask

   task automatic drive1(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
      req1 = r; wEn1 = w; addr1 = a; wData1 = d; size1 = s;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive0(1'b1, 1'b1, 32'h40, 32'h12345678, 3'b010);
      drive1(1'b1, 1'b0, 32'h44, 32'h0, 3'b010);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); end
      checks++; if (memWEn !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", memWEn); end
      checks++; if ({rvalid0, rvalid1, err0, err1} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {rvalid0, rvalid1, err0, err1}); end
      checks++; if ({rData0, rData1} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {rData0, rData1}); end
      checks++; if ({dbg_force, dbg_wait_cnt} !== 5'b0) begin errors++; $display("FAIL reset_state: got %b want 0", {dbg_force, dbg_wait_cnt}); end
      checks++; if (mem[12'h040] !== init_byte(32'h40)) begin errors++; $display("FAIL reset_nowrite: got %h want %h", mem[12'h040], init_byte(32'h40)); end
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_store_load();
      drive0(1'b1, 1'b1, 32'h100, 32'hCAFEBABE, 3'b010);
      cycle();
      checks++; if ({o_g0, o_g1, o_wen} !== 3'b101) begin errors++; $display("FAIL sl_store_bus: got %b want 101", {o_g0, o_g1, o_wen}); end
      checks++; if (o_addr !== 32'h100 || o_wdata !== 32'hCAFEBABE) begin errors++; $display("FAIL sl_store_addr: got %h/%h want 100/cafebabe", o_addr, o_wdata); end
      drive0(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
      cycle();
      checks++; if ({o_g0, o_wen} !== 2'b10) begin errors++; $display("FAIL sl_load_bus: got %b want 10", {o_g0, o_wen}); end
      checks++; if (o_rv !== 2'b01 || o_rd0 !== 32'hCAFEBABE) begin errors++; $display("FAIL sl_load_data: got %b/%h want 01/cafebabe", o_rv, o_rd0); end
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      cycle();
      checks++; if (o_rv !== 2'b00 || o_rd0 !== 32'hCAFEBABE) begin errors++; $display("FAIL sl_hold: got %b/%h want 00/cafebabe", o_rv, o_rd0); end
   endtask

   task automatic test_starvation();
      logic want1;
      for (int k = 0; k < 15; k++) begin
         drive0(1'b1, 1'b0, 32'($urandom_range(0, 4095)), 32'h0, 3'b010);
         drive1(1'b1, 1'b0, 32'($urandom_range(0, 4095)), 32'h0, 3'b100);
         cycle();
         want1 = ((k % 5) == 4);
         checks++; if ({o_g0, o_g1} !== {!want1, want1}) begin errors++; $display("FAIL starve_gnt[%0d]: got %b want %b", k, {o_g0, o_g1}, {!want1, want1}); end
         checks++; if (o_rv !== e_rv || o_rd0 !== e_rd0 || o_rd1 !== e_rd1) begin errors++; $display("FAIL starve_load[%0d]: got %b/%h/%h want %b/%h/%h", k, o_rv, o_rd0, o_rd1, e_rv, e_rd0, e_rd1); end
      end
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      cycle();
   endtask

   task automatic test_port1_byte();
      drive1(1'b1, 1'b1, 32'h300, 32'h00000080, 3'b000);
      cycle();
      drive1(1'b1, 1'b0, 32'h300, 32'h0, 3'b000);
      cycle();
      checks++; if ({o_g0, o_g1} !== 2'b01) begin errors++; $display("FAIL p1b_gnt: got %b want 01", {o_g0, o_g1}); end
      checks++; if (o_rv !== 2'b10 || o_rd1 !== 32'hFFFFFF80) begin errors++; $display("FAIL p1b_signed: got %b/%h want 10/ffffff80", o_rv, o_rd1); end
      drive1(1'b1, 1'b0, 32'h300, 32'h0, 3'b100);
      cycle();
      checks++; if (o_rv !== 2'b10 || o_rd1 !== 32'h00000080) begin errors++; $display("FAIL p1b_unsigned: got %b/%h want 10/00000080", o_rv, o_rd1); end
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
   endtask

   task automatic test_illegal_store();
      drive0(1'b1, 1'b1, 32'h200, 32'h00000011, 3'b000);
      cycle();
      drive0(1'b1, 1'b1, 32'h200, 32'h00000022, 3'b100);
      cycle();
      checks++; if ({o_g0, o_wen} !== 2'b10) begin errors++; $display("FAIL ill_st_bus: got %b want 10", {o_g0, o_wen}); end
      checks++; if (o_er !== 2'b01 || o_rv !== 2'b00) begin errors++; $display("FAIL ill_st_err: got %b/%b want 01/00", o_er, o_rv); end
      drive0(1'b1, 1'b0, 32'h200, 32'h0, 3'b100);
      cycle();
      checks++; if (o_er !== 2'b00 || o_rv !== 2'b01 || o_rd0 !== 32'h11) begin errors++; $display("FAIL ill_st_readback: got %b/%b/%h want 00/01/00000011", o_er, o_rv, o_rd0); end
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
   endtask

   task automatic test_illegal_load();
      drive1(1'b1, 1'b0, 32'h300, 32'h0, 3'b111);
      cycle();
      checks++; if ({o_g1, o_wen} !== 2'b10) begin errors++; $display("FAIL ill_ld_bus: got %b want 10", {o_g1, o_wen}); end
      checks++; if (o_er !== 2'b10 || o_rv !== 2'b00 || o_rd1 !== 32'h00000080) begin errors++; $display("FAIL ill_ld: got %b/%b/%h want 10/00/00000080", o_er, o_rv, o_rd1); end
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      cycle();
      checks++; if (o_er !== 2'b00) begin errors++; $display("FAIL ill_ld_pulse: got %b want 00", o_er); end
   endtask

   task automatic test_reset_mid();
      drive0(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
      drive1(1'b1, 1'b0, 32'h104, 32'h0, 3'b010);
      cycle();
      cycle();
      checks++; if (o_rv !== 2'b01 || dbg_wait_cnt !== 4'd2) begin errors++; $display("FAIL mid_pre: got %b/%0d want 01/2", o_rv, dbg_wait_cnt); end
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (rvalid0 !== 1'b0 || rData0 !== 32'h0) begin errors++; $display("FAIL mid_drop: got %b/%h want 0/0", rvalid0, rData0); end
      checks++; if ({dbg_force, dbg_wait_cnt} !== 5'b0) begin errors++; $display("FAIL mid_state: got %b want 0", {dbg_force, dbg_wait_cnt}); end
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive1(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
      cycle();
      checks++; if (o_g1 !== 1'b1 || o_rv !== 2'b10 || o_rd1 !== 32'hCAFEBABE) begin errors++; $display("FAIL mid_after: got %b/%b/%h want 1/10/cafebabe", o_g1, o_rv, o_rd1); end
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      cycle();
   endtask

   task automatic test_random();
      logic [2:0] legal_sz [5];
      legal_sz = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int n = 0; n < 300; n++) begin
         drive0($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom,
                $urandom, ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_sz[$urandom_range(0, 4)]);
         drive1($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom,
                $urandom, ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_sz[$urandom_range(0, 4)]);
         cycle();
         checks++; if ({o_g0, o_g1} !== {e_g0, e_g1}) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, {o_g0, o_g1}, {e_g0, e_g1}); end
         checks++; if ({o_wen, o_addr, o_wdata, o_size} !== {e_wen, e_addr, e_wdata, e_size}) begin errors++; $display("FAIL rnd_bus[%0d]: got %b/%h/%h/%b want %b/%h/%h/%b", n, o_wen, o_addr, o_wdata, o_size, e_wen, e_addr, e_wdata, e_size); end
         checks++; if ({o_rv, o_er} !== {e_rv, e_er}) begin errors++; $display("FAIL rnd_pulse[%0d]: got %b/%b want %b/%b", n, o_rv, o_er, e_rv, e_er); end
         checks++; if (o_rd0 !== e_rd0 || o_rd1 !== e_rd1) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", n, o_rd0, o_rd1, e_rd0, e_rd1); end
      end
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
      test_reset();
      test_store_load();
      test_starvation();
      test_port1_byte();
      test_illegal_store();
      test_illegal_load();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
